mem_stage: RTL and testbench

Memory stage of the Y86-64 pipeline: consumer of the execute-stage outputs (e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM). Holds the E→M pipeline register and a byte-addressed little-endian data memory. Performs the 8-byte load or store selected by M_icode and produces m_* results for the M→W register. Also exports the registered M_* fields needed for forwarding and mispredicted-jump recovery.

---
 rtl/y86_pkg.sv | 59 +++++
 rtl/data_mem.sv | 42 ++++
 rtl/mem_stage.sv | 100 ++++++++++
 tb/tb_mem_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants, M-register layout and memory-access decode.
// Pure declarations; no timing of its own.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_e;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } mreg_t;

  localparam mreg_t MREG_BUBBLE = '{
    stat:  SAOK,
    icode: INOP,
    cnd:   1'b0,
    val_e: 64'd0,
    val_a: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  function automatic acc_e mem_access(input logic [3:0] icode);
    case (icode)
      IMRMOVQ, IRET, IPOPQ:   return ACC_READ;
      IRMMOVQ, ICALL, IPUSHQ: return ACC_WRITE;
      default:                return ACC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory: 8-byte combinational read, 8-byte write on rising edge.
// err flags any address past the last full 8-byte word; faulting writes are dropped, faulting reads return 0.
module data_mem #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        wr_en,
  output logic [63:0] rd_data,
  output logic        err
);
  import y86_pkg::*;

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_OK  = 64'(MEM_BYTES - 8);

  logic [7:0]    mem_q [MEM_BYTES];
  logic [AW-1:0] base;

  // Full-width compare so huge addresses never alias onto low memory.
  assign err  = addr > LAST_OK;
  assign base = addr[AW-1:0];

  always_comb begin
    rd_data = '0;
    if (!err) begin
      for (int i = 0; i < 8; i++) begin
        rd_data[8*i +: 8] = mem_q[base + AW'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !err) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[base + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: E->M register (1-cycle latency), load/store, status merge, sticky halt.
// No internal backpressure; M_stall holds and M_bubble squashes the M register, stall winning.
module mem_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        M_stall,
  input  logic        M_bubble,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [1:0]  m_stat,
  output logic [3:0]  m_icode,
  output logic [3:0]  m_dstE,
  output logic [3:0]  m_dstM,
  output logic [63:0] m_valE,
  output logic [63:0] m_valM,
  output logic        mem_error
);
  import y86_pkg::*;

  mreg_t       m_reg_d, m_reg_q;
  logic        halted_d, halted_q;
  acc_e        acc;
  logic [63:0] mem_addr;
  logic [63:0] rd_data;
  logic        addr_err;
  logic        wr_en;

  always_comb begin
    m_reg_d = m_reg_q;
    if (!M_stall) begin
      if (M_bubble) begin
        m_reg_d = MREG_BUBBLE;
      end else begin
        m_reg_d = '{stat: e_stat, icode: e_icode, cnd: e_cnd, val_e: e_valE,
                    val_a: e_valA, dst_e: e_dstE, dst_m: e_dstM};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg_q  <= MREG_BUBBLE;
      halted_q <= 1'b0;
    end else begin
      m_reg_q  <= m_reg_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    acc = mem_access(m_reg_q.icode);
    case (m_reg_q.icode)
      IRMMOVQ, IMRMOVQ, ICALL, IPUSHQ: mem_addr = m_reg_q.val_e;
      IRET, IPOPQ:                     mem_addr = m_reg_q.val_a;
      default:                         mem_addr = '0;
    endcase

    mem_error = (acc != ACC_NONE) && addr_err;
    m_stat    = mem_error ? SADR : m_reg_q.stat;
    m_valM    = (acc == ACC_READ && !mem_error) ? rd_data : '0;

    // A store sitting in M across a reset edge must not land.
    wr_en     = (acc == ACC_WRITE) && !halted_q && !rst;
    halted_d  = halted_q || (m_stat != SAOK);
  end

  data_mem #(.MEM_BYTES(MEM_BYTES)) u_mem (
    .clk     (clk),
    .addr    (mem_addr),
    .wdata   (m_reg_q.val_a),
    .wr_en   (wr_en),
    .rd_data (rd_data),
    .err     (addr_err)
  );

  assign M_icode = m_reg_q.icode;
  assign M_dstE  = m_reg_q.dst_e;
  assign M_dstM  = m_reg_q.dst_m;
  assign M_cnd   = m_reg_q.cnd;
  assign M_valE  = m_reg_q.val_e;
  assign M_valA  = m_reg_q.val_a;
  assign m_icode = m_reg_q.icode;
  assign m_dstE  = m_reg_q.dst_e;
  assign m_dstM  = m_reg_q.dst_m;
  assign m_valE  = m_reg_q.val_e;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// against a byte-array reference model of the memory and the M register.
module tb_mem_stage;
  localparam int MEM_BYTES = 1024;
  localparam int AW = $clog2(MEM_BYTES);

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_cnd;
  logic [63:0] e_valE, e_valA;
  logic [3:0]  e_dstE, e_dstM;
  logic        M_stall, M_bubble;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA;
  logic [1:0]  m_stat;
  logic [3:0]  m_icode, m_dstE, m_dstM;
  logic [63:0] m_valE, m_valM;
  logic        mem_error;

  always #5 clk = ~clk;

  mem_stage #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd), .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .M_stall(M_stall), .M_bubble(M_bubble),
    .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .m_stat(m_stat), .m_icode(m_icode),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .m_valE(m_valE), .m_valM(m_valM),
    .mem_error(mem_error)
  );

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } ins_t;

  ins_t       cur;
  logic [7:0] ref_mem [MEM_BYTES];
  bit         ref_halted;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic ins_t mk(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
    ins_t x;
    x.stat = 2'd0; x.icode = ic; x.cnd = 1'b0; x.valE = ve; x.valA = va;
    x.dstE = 4'hF; x.dstM = 4'hF;
    return x;
  endfunction

  function automatic bit reads(input logic [3:0] ic);
    return ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
  endfunction

  function automatic bit writes(input logic [3:0] ic);
    return ic == 4'h4 || ic == 4'h8 || ic == 4'hA;
  endfunction

  function automatic logic [63:0] addr_of(input ins_t x);
    return (x.icode == 4'h9 || x.icode == 4'hB) ? x.valA : x.valE;
  endfunction

  function automatic bit faults(input ins_t x);
    return (reads(x.icode) || writes(x.icode)) && (addr_of(x) > 64'(MEM_BYTES - 8));
  endfunction

  function automatic logic [1:0] exp_stat(input ins_t x);
    return faults(x) ? 2'd2 : x.stat;
  endfunction

  function automatic logic [63:0] ref_word(input logic [63:0] a);
    logic [63:0]   v;
    logic [AW-1:0] ix;
    for (int i = 0; i < 8; i++) begin
      ix = a[AW-1:0] + AW'(i);
      v[8*i +: 8] = ref_mem[ix];
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_load(input ins_t x);
    if (reads(x.icode) && !faults(x)) return ref_word(addr_of(x));
    return 64'd0;
  endfunction

  // One clock: present e/stall/bubble/rst, then advance the model across the edge.
  task automatic cycle(input ins_t e, input logic st, input logic bu, input logic r);
    logic [63:0]   a;
    logic [AW-1:0] ix;
    e_stat = e.stat; e_icode = e.icode; e_cnd = e.cnd; e_valE = e.valE; e_valA = e.valA;
    e_dstE = e.dstE; e_dstM = e.dstM; M_stall = st; M_bubble = bu; rst = r;
    @(posedge clk);
    if (r) begin
      cur = mk(4'h1, 64'd0, 64'd0);
      ref_halted = 1'b0;
    end else begin
      if (writes(cur.icode) && !faults(cur) && !ref_halted) begin
        a = addr_of(cur);
        for (int i = 0; i < 8; i++) begin
          ix = a[AW-1:0] + AW'(i);
          ref_mem[ix] = cur.valA[8*i +: 8];
        end
      end
      if (exp_stat(cur) != 2'd0) ref_halted = 1'b1;
      if (!st) cur = bu ? mk(4'h1, 64'd0, 64'd0) : e;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(mk(4'h1, 64'd0, 64'd0), 1'b0, 1'b0, 1'b1);
    cycle(mk(4'hA, 64'h8, 64'h5), 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({M_icode, M_dstE, M_dstM, M_cnd, M_valE, M_valA} !== {4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0}) begin
      n_bad++;
      $display("FAIL reset_M got=%h exp=%h", {M_icode, M_dstE, M_dstM, M_cnd, M_valE, M_valA},
               {4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0});
    end
    n_cmp++;
    if ({m_stat, mem_error, m_icode, m_dstE, m_dstM, m_valE, m_valM} !==
        {2'd0, 1'b0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0}) begin
      n_bad++;
      $display("FAIL reset_m got=%h exp=%h", {m_stat, mem_error, m_icode, m_dstE, m_dstM, m_valE, m_valM},
               {2'd0, 1'b0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0});
    end
  endtask

  task automatic init_mem();
    for (int w = 0; w < MEM_BYTES / 8; w++)
      cycle(mk(4'h4, 64'(w * 8), {$urandom, $urandom}), 1'b0, 1'b0, 1'b0);
    cycle(mk(4'h1, 64'd0, 64'd0), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_store_load();
    cycle(mk(4'h4, 64'h40, 64'h1122334455667788), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({m_stat, mem_error, m_valM} !== {2'd0, 1'b0, 64'd0}) begin
      n_bad++;
      $display("FAIL store_status got=%h exp=%h", {m_stat, mem_error, m_valM}, {2'd0, 1'b0, 64'd0});
    end
    cycle(mk(4'h5, 64'h40, 64'd0), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (m_valM !== 64'h1122334455667788) begin
      n_bad++;
      $display("FAIL store_load got=%h exp=%h", m_valM, 64'h1122334455667788);
    end
    cycle(mk(4'h5, 64'h3F, 64'd0), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (m_valM[15:8] !== 8'h88) begin
      n_bad++;
      $display("FAIL little_endian_byte40 got=%h exp=%h", m_valM[15:8], 8'h88);
    end
  endtask

  task automatic test_push_pop();
    cycle(mk(4'hA, 64'h1F8, 64'hABCD), 1'b0, 1'b0, 1'b0);
    cycle(mk(4'hB, 64'h200, 64'h1F8), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({m_valM, m_valE} !== {64'hABCD, 64'h200}) begin
      n_bad++;
      $display("FAIL push_pop got=%h exp=%h", {m_valM, m_valE}, {64'hABCD, 64'h200});
    end
  endtask

  task automatic test_addr_fault();
    logic [63:0] before_lo, before_hi;
    before_lo = ref_word(64'h10);
    before_hi = ref_word(64'(MEM_BYTES - 8));
    cycle(mk(4'h4, 64'(MEM_BYTES - 7), 64'hDEADBEEFDEADBEEF), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({m_stat, mem_error} !== {2'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL fault_flag got=%h exp=%h", {m_stat, mem_error}, {2'd2, 1'b1});
    end
    cycle(mk(4'h4, 64'h10, 64'h5555AAAA5555AAAA), 1'b0, 1'b0, 1'b0);
    cycle(mk(4'h5, 64'h10, 64'd0), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (m_valM !== before_lo) begin
      n_bad++;
      $display("FAIL halted_blocks_store got=%h exp=%h", m_valM, before_lo);
    end
    cycle(mk(4'h5, 64'(MEM_BYTES - 8), 64'd0), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (m_valM !== before_hi) begin
      n_bad++;
      $display("FAIL fault_no_write got=%h exp=%h", m_valM, before_hi);
    end
    cycle(mk(4'h1, 64'd0, 64'd0), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_huge_addr();
    cycle(mk(4'h5, 64'hFFFFFFFFFFFFFFFC, 64'd0), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({m_stat, mem_error, m_valM} !== {2'd2, 1'b1, 64'd0}) begin
      n_bad++;
      $display("FAIL huge_addr got=%h exp=%h", {m_stat, mem_error, m_valM}, {2'd2, 1'b1, 64'd0});
    end
    cycle(mk(4'h1, 64'd0, 64'd0), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stall_bubble();
    ins_t x, y;
    logic [63:0] w88;
    x = mk(4'h2, 64'h1234, 64'h99); x.dstE = 4'h3; x.cnd = 1'b1;
    y = mk(4'h4, 64'h80, 64'h7777);
    cycle(x, 1'b0, 1'b0, 1'b0);
    cycle(y, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({M_icode, M_valE, M_dstE, M_cnd} !== {4'h2, 64'h1234, 4'h3, 1'b1}) begin
      n_bad++;
      $display("FAIL stall_hold got=%h exp=%h", {M_icode, M_valE, M_dstE, M_cnd}, {4'h2, 64'h1234, 4'h3, 1'b1});
    end
    cycle(y, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({M_icode, M_valE, M_dstE, M_cnd} !== {4'h2, 64'h1234, 4'h3, 1'b1}) begin
      n_bad++;
      $display("FAIL stall_over_bubble got=%h exp=%h", {M_icode, M_valE, M_dstE, M_cnd}, {4'h2, 64'h1234, 4'h3, 1'b1});
    end
    cycle(y, 1'b0, 1'b0, 1'b0);
    w88 = ref_word(64'h88);
    cycle(mk(4'h4, 64'h88, 64'hF00DF00D), 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({M_icode, M_dstE, M_dstM} !== {4'h1, 4'hF, 4'hF}) begin
      n_bad++;
      $display("FAIL bubble_nop got=%h exp=%h", {M_icode, M_dstE, M_dstM}, {4'h1, 4'hF, 4'hF});
    end
    cycle(mk(4'h5, 64'h88, 64'd0), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (m_valM !== w88) begin
      n_bad++;
      $display("FAIL bubble_no_write got=%h exp=%h", m_valM, w88);
    end
    cycle(mk(4'h5, 64'h80, 64'd0), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (m_valM !== 64'h7777) begin
      n_bad++;
      $display("FAIL store_after_stall got=%h exp=%h", m_valM, 64'h7777);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w100;
    cycle(mk(4'h4, 64'(MEM_BYTES), 64'd1), 1'b0, 1'b0, 1'b0);
    w100 = ref_word(64'h100);
    cycle(mk(4'hA, 64'h100, 64'hCAFE), 1'b0, 1'b0, 1'b0);
    cycle(mk(4'h1, 64'd0, 64'd0), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({M_icode, m_stat} !== {4'h1, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_mid_state got=%h exp=%h", {M_icode, m_stat}, {4'h1, 2'd0});
    end
    cycle(mk(4'h5, 64'h100, 64'd0), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (m_valM !== w100) begin
      n_bad++;
      $display("FAIL reset_blocks_push got=%h exp=%h", m_valM, w100);
    end
    cycle(mk(4'h4, 64'h108, 64'hBEEF), 1'b0, 1'b0, 1'b0);
    cycle(mk(4'h5, 64'h108, 64'd0), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (m_valM !== 64'hBEEF) begin
      n_bad++;
      $display("FAIL store_after_reset got=%h exp=%h", m_valM, 64'hBEEF);
    end
  endtask

  task automatic test_random();
    ins_t        e;
    logic [63:0] a;
    logic        st, bu, r;
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: e.icode = 4'($urandom_range(0, 15));
        3:       e.icode = 4'h4;
        4:       e.icode = 4'h5;
        5:       e.icode = 4'h8;
        6:       e.icode = 4'h9;
        7:       e.icode = 4'hA;
        default: e.icode = 4'hB;
      endcase
      case ($urandom_range(0, 11))
        0:       a = 64'(MEM_BYTES - 8) + 64'($urandom_range(1, 16));
        1:       a = {$urandom, $urandom};
        default: a = 64'($urandom_range(0, MEM_BYTES - 8));
      endcase
      e.stat = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      e.cnd  = 1'($urandom);
      e.valE = {$urandom, $urandom};
      e.valA = {$urandom, $urandom};
      if (e.icode == 4'h9 || e.icode == 4'hB) e.valA = a; else e.valE = a;
      e.dstE = 4'($urandom);
      e.dstM = 4'($urandom);
      st = ($urandom_range(0, 9) == 0);
      bu = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 24) == 0);
      cycle(e, st, bu, r);
      n_cmp++;
      if ({M_icode, M_dstE, M_dstM, M_cnd, M_valE, M_valA} !==
          {cur.icode, cur.dstE, cur.dstM, cur.cnd, cur.valE, cur.valA}) begin
        n_bad++;
        $display("FAIL rnd_Mreg k=%0d got=%h exp=%h", k, {M_icode, M_dstE, M_dstM, M_cnd, M_valE, M_valA},
                 {cur.icode, cur.dstE, cur.dstM, cur.cnd, cur.valE, cur.valA});
      end
      n_cmp++;
      if ({m_icode, m_dstE, m_dstM, m_valE} !== {cur.icode, cur.dstE, cur.dstM, cur.valE}) begin
        n_bad++;
        $display("FAIL rnd_pass k=%0d got=%h exp=%h", k, {m_icode, m_dstE, m_dstM, m_valE},
                 {cur.icode, cur.dstE, cur.dstM, cur.valE});
      end
      n_cmp++;
      if ({m_stat, mem_error, m_valM} !== {exp_stat(cur), faults(cur), exp_load(cur)}) begin
        n_bad++;
        $display("FAIL rnd_mem k=%0d got=%h exp=%h", k, {m_stat, mem_error, m_valM},
                 {exp_stat(cur), faults(cur), exp_load(cur)});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    ref_halted = 1'b0;
    cur = mk(4'h1, 64'd0, 64'd0);
    test_reset();
    init_mem();
    test_store_load();
    test_push_pop();
    test_addr_fault();
    test_huge_addr();
    test_stall_bubble();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
